// File: rtl/uart_i2c_cmd_engine.sv
// UART framed-command engine: parses 0x55 frames, runs single-byte
// I2C writes/reads with auto-increment, and returns a status frame.
module uart_i2c_cmd_engine #(
  parameter int ADDR_BYTES = 2,
  parameter int MAX_LEN    = 16,
  parameter int RX_TIMEOUT = 50000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_done,
  output logic [7:0]  i2c_dev_id,
  output logic [15:0] i2c_addr,
  output logic        i2c_addr_mode,
  output logic [7:0]  i2c_wrdata,
  output logic        i2c_wr_req,
  output logic        i2c_rd_req,
  input  logic [7:0]  i2c_rddata,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        busy
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAXL = 8'(MAX_LEN);
  localparam logic [31:0] TMO_LAST = 32'(RX_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, CMD, DEV, ADDR, LEN, DATA, DRAIN,
    I2C_REQ, I2C_WAIT, RESP_HDR, RESP_STAT, RESP_DATA
  } state_t;

  state_t      state;
  logic [7:0]  cmd, len, idx, status;
  logic [31:0] tmo;
  logic        acnt, tx_pend;
  logic [7:0]  buf_q [MAX_LEN];
  logic        is_rd, timed, expired, last;
  logic [IW-1:0] bi, bi_n;
  logic [15:0] next_addr;

  assign is_rd   = cmd == 8'h02;
  assign timed   = state inside {CMD, DEV, ADDR, LEN, DATA, DRAIN};
  assign expired = timed && !rx_done && tmo == TMO_LAST;
  assign last    = idx == len - 8'd1;
  assign bi      = idx[IW-1:0];
  assign bi_n    = IW'(idx + 8'd1);
  assign next_addr = (ADDR_BYTES == 2) ? i2c_addr + 16'd1
                   : {8'h00, i2c_addr[7:0] + 8'd1};

  always_ff @(posedge Clk) begin
    if (state == DATA && rx_done)
      buf_q[bi] <= rx_data;
    else if (state == I2C_WAIT && i2c_done && !i2c_nack && is_rd)
      buf_q[bi] <= i2c_rddata;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state         <= IDLE;
      cmd           <= '0;
      len           <= '0;
      idx           <= '0;
      status        <= '0;
      tmo           <= '0;
      acnt          <= 1'b0;
      tx_pend       <= 1'b0;
      tx_data       <= '0;
      tx_send       <= 1'b0;
      i2c_dev_id    <= '0;
      i2c_addr      <= '0;
      i2c_addr_mode <= 1'b0;
      i2c_wrdata    <= '0;
      i2c_wr_req    <= 1'b0;
      i2c_rd_req    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      tx_send       <= 1'b0;
      i2c_wr_req    <= 1'b0;
      i2c_rd_req    <= 1'b0;
      i2c_addr_mode <= ADDR_BYTES == 2;
      if (!timed || rx_done) tmo <= '0;
      else tmo <= tmo + 32'd1;
      if (expired) begin
        if (state == DRAIN) begin
          state   <= RESP_HDR;
          tx_pend <= 1'b0;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end else begin
        unique case (state)
          IDLE: if (rx_done && rx_data == 8'h55) begin
            state  <= CMD;
            busy   <= 1'b1;
            status <= 8'h00;
            idx    <= '0;
          end
          CMD: if (rx_done) begin
            cmd   <= rx_data;
            state <= DEV;
          end
          DEV: if (rx_done) begin
            i2c_dev_id <= rx_data & 8'hFE;
            acnt       <= 1'b0;
            state      <= ADDR;
          end
          ADDR: if (rx_done) begin
            i2c_addr <= (ADDR_BYTES == 2) ? {i2c_addr[7:0], rx_data}
                                          : {8'h00, rx_data};
            acnt <= 1'b1;
            if (ADDR_BYTES == 1 || acnt) state <= LEN;
          end
          LEN: if (rx_done) begin
            len <= rx_data;
            idx <= '0;
            if (rx_data == 8'd0 || rx_data > MAXL ||
                !(cmd == 8'h01 || cmd == 8'h02)) begin
              state  <= DRAIN;
              status <= 8'h02;
            end else if (cmd == 8'h01) begin
              state <= DATA;
            end else begin
              state      <= I2C_REQ;
              i2c_rd_req <= 1'b1;
            end
          end
          DATA: if (rx_done) begin
            if (last) begin
              state      <= I2C_REQ;
              idx        <= '0;
              i2c_wr_req <= 1'b1;
              // single-byte burst: buffer[0] is being written this edge
              i2c_wrdata <= (idx == 8'd0) ? rx_data : buf_q[0];
            end else begin
              idx <= idx + 8'd1;
            end
          end
          DRAIN: ;
          I2C_REQ: state <= I2C_WAIT;
          I2C_WAIT: if (i2c_done) begin
            if (i2c_nack) begin
              status  <= 8'h01;
              state   <= RESP_HDR;
              tx_pend <= 1'b0;
            end else begin
              i2c_addr <= next_addr;
              if (last) begin
                status  <= 8'h00;
                state   <= RESP_HDR;
                tx_pend <= 1'b0;
              end else begin
                idx   <= idx + 8'd1;
                state <= I2C_REQ;
                if (is_rd) begin
                  i2c_rd_req <= 1'b1;
                end else begin
                  i2c_wr_req <= 1'b1;
                  i2c_wrdata <= buf_q[bi_n];
                end
              end
            end
          end
          RESP_HDR: begin
            if (!tx_pend) begin
              tx_send <= 1'b1;
              tx_data <= 8'hAA;
              tx_pend <= 1'b1;
            end else if (tx_done) begin
              state   <= RESP_STAT;
              tx_send <= 1'b1;
              tx_data <= status;
            end
          end
          RESP_STAT: if (tx_done) begin
            if (is_rd && status == 8'h00) begin
              state   <= RESP_DATA;
              idx     <= '0;
              tx_send <= 1'b1;
              tx_data <= buf_q[0];
            end else begin
              state   <= IDLE;
              busy    <= 1'b0;
              tx_pend <= 1'b0;
            end
          end
          RESP_DATA: if (tx_done) begin
            if (last) begin
              state   <= IDLE;
              busy    <= 1'b0;
              tx_pend <= 1'b0;
            end else begin
              idx     <= idx + 8'd1;
              tx_send <= 1'b1;
              tx_data <= buf_q[bi_n];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_i2c_cmd_engine.sv
// Bench for uart_i2c_cmd_engine: frame-level model of expected I2C
// operations and UART response bytes, compared on every cycle.
module tb_uart_i2c_cmd_engine;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_done = 1'b0;
  logic [7:0]  i2c_dev_id;
  logic [15:0] i2c_addr;
  logic        i2c_addr_mode;
  logic [7:0]  i2c_wrdata;
  logic        i2c_wr_req, i2c_rd_req;
  logic [7:0]  i2c_rddata = 8'h00;
  logic        i2c_done = 1'b0, i2c_nack = 1'b0;
  logic        busy;

  uart_i2c_cmd_engine #(
    .ADDR_BYTES(2), .MAX_LEN(16), .RX_TIMEOUT(TMO)
  ) dut (
    .Clk(clk), .Rst_n(rst_n),
    .rx_data(rx_data), .rx_done(rx_done),
    .tx_data(tx_data), .tx_send(tx_send), .tx_done(tx_done),
    .i2c_dev_id(i2c_dev_id), .i2c_addr(i2c_addr),
    .i2c_addr_mode(i2c_addr_mode), .i2c_wrdata(i2c_wrdata),
    .i2c_wr_req(i2c_wr_req), .i2c_rd_req(i2c_rd_req),
    .i2c_rddata(i2c_rddata), .i2c_done(i2c_done),
    .i2c_nack(i2c_nack), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { bit rd; logic [15:0] addr; logic [7:0] data; } op_t;
  typedef struct { logic [7:0] b; bit first; } tx_t;

  op_t exp_i2c[$];
  tx_t exp_tx[$];
  int  checks = 0, errors = 0;
  int  n_req = 0, evt_cyc = 0, rx_cyc = 0, txd_cyc = 0;
  int  first_tx_cyc = 0, fall_cyc = -1;
  bit  outstanding = 0;
  logic [7:0] sent_b = 8'h00;
  int  n_done = 0, nack_at = -1;
  bit  hold_done = 0;
  logic [7:0] mem [65536];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [15:0] a);
    case (a)
      16'h01FE: return 8'h5A;
      16'h01FF: return 8'h6B;
      16'hFFFF: return 8'hC3;
      16'h0000: return 8'hD4;
      default:  return a[7:0] ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  // I2C slave: completes each request 3 cycles later
  int s_wait = 0;
  bit s_act = 0, s_rd = 0;
  logic [15:0] s_addr = 16'h0;
  logic [7:0]  s_data = 8'h0;
  always @(posedge clk) begin
    #1;
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    if (!rst_n) s_act = 0;
    else if (s_act) begin
      if (s_wait > 0) s_wait--;
      else if (!hold_done) begin
        i2c_done = 1'b1;
        i2c_nack = (n_done == nack_at);
        s_act = 0;
        if (s_rd) i2c_rddata = rd_byte(s_addr);
        else if (!i2c_nack) mem[s_addr] = s_data;
        n_done++;
      end
    end
    if (rst_n && (i2c_wr_req || i2c_rd_req)) begin
      s_act = 1; s_wait = 2; s_rd = i2c_rd_req;
      s_addr = i2c_addr; s_data = i2c_wrdata;
    end
  end

  // UART transmitter: tx_done 4 cycles after tx_send
  int t_cnt = -1;
  always @(posedge clk) begin
    #1;
    tx_done = 1'b0;
    if (!rst_n) t_cnt = -1;
    else if (t_cnt > 0) t_cnt--;
    else if (t_cnt == 0) begin tx_done = 1'b1; t_cnt = -1; end
    if (rst_n && tx_send) t_cnt = 3;
  end

  always @(negedge clk) begin : cmp
    op_t e;
    tx_t t;
    if (!rst_n) outstanding = 0;
    else begin
      if (i2c_wr_req || i2c_rd_req) begin
        n_req++;
        chk("i2c_latency", cyc, evt_cyc + 1);
        chk("i2c_one_outstanding", 32'(outstanding), 0);
        chk("i2c_one_kind", 32'(i2c_wr_req & i2c_rd_req), 0);
        outstanding = 1;
        chk("i2c_pending_exp", 32'(exp_i2c.size() > 0), 1);
        if (exp_i2c.size() > 0) begin
          e = exp_i2c.pop_front();
          chk("i2c_kind", 32'(i2c_rd_req), 32'(e.rd));
          chk("i2c_addr", i2c_addr, e.addr);
          chk("i2c_dev", i2c_dev_id, 8'hA0);
          if (!e.rd) chk("i2c_wrdata", i2c_wrdata, e.data);
        end
      end
      if (i2c_done) begin outstanding = 0; evt_cyc = cyc; end
      if (rx_done) begin evt_cyc = cyc; rx_cyc = cyc; end
      if (tx_send) begin
        chk("tx_pending_exp", 32'(exp_tx.size() > 0), 1);
        if (exp_tx.size() > 0) begin
          t = exp_tx.pop_front();
          chk("tx_byte", tx_data, t.b);
          if (t.first) first_tx_cyc = cyc;
          else chk("tx_latency", cyc, txd_cyc + 1);
          chk("busy_during_tx", 32'(busy), 1);
        end
        sent_b = tx_data;
      end
      if (tx_done) begin
        txd_cyc = cyc;
        chk("tx_data_held", tx_data, sent_b);
        if (exp_tx.size() == 0) begin
          chk("busy_at_last_done", 32'(busy), 1);
          fall_cyc = cyc + 1;
        end
      end
      if (cyc == fall_cyc) begin
        chk("busy_fall", 32'(busy), 0);
        fall_cyc = -1;
      end
    end
  end

  task automatic model(input bit rd, input logic [15:0] a, input int len,
                       input logic [7:0] d[$], input int nack_i);
    op_t o;
    tx_t t;
    bit nk = 0;
    for (int i = 0; i < len && !nk; i++) begin
      o.rd = rd;
      o.addr = a + 16'(i);
      o.data = 8'h00;
      if (!rd) o.data = d[i];
      exp_i2c.push_back(o);
      nk = (i == nack_i);
    end
    t.first = 1; t.b = 8'hAA; exp_tx.push_back(t);
    t.first = 0; t.b = nk ? 8'h01 : 8'h00; exp_tx.push_back(t);
    if (rd && !nk)
      for (int i = 0; i < len; i++) begin
        t.b = rd_byte(a + 16'(i));
        exp_tx.push_back(t);
      end
  endtask

  task automatic model_bad();
    tx_t t;
    t.first = 1; t.b = 8'hAA; exp_tx.push_back(t);
    t.first = 0; t.b = 8'h02; exp_tx.push_back(t);
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    foreach (f[i]) begin
      @(posedge clk); #1;
      rx_data = f[i];
      rx_done = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0;
      repeat (2) @(posedge clk);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_i2c.size() != 0 || exp_tx.size() != 0 || busy) &&
           n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_budget", 32'(n < budget), 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_addr"}, 32'(i2c_addr), 0);
    chk({nm, "_misc"}, {4'h0, tx_data, tx_send, i2c_wr_req, i2c_rd_req,
                        i2c_addr_mode, i2c_dev_id, i2c_wrdata}, 0);
  endtask

  task automatic chk_drain();
    int d;
    d = first_tx_cyc - rx_cyc;
    chk("drain_delay", 32'(d >= TMO && d <= TMO + 4), 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr[$];
    logic [7:0] dq[$];
    int r0, n;

    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("addr_mode", 32'(i2c_addr_mode), 1);

    // burst write
    dq = '{8'h11, 8'h22, 8'h33};
    model(0, 16'h0010, 3, dq, -1);
    chk("pin_wr_ops", exp_i2c.size(), 3);
    chk("pin_wr_addr2", exp_i2c[2].addr, 16'h0012);
    chk("pin_wr_resp", {exp_tx[0].b, exp_tx[1].b}, 16'hAA00);
    r0 = n_req;
    fr = '{8'h55, 8'h01, 8'hA0, 8'h00, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33};
    send_frame(fr);
    wait_done(500);
    chk("wr_reqs", n_req - r0, 3);
    chk("wr_mem", mem[16'h0011], 8'h22);

    // burst read
    dq = {};
    model(1, 16'h01FE, 2, dq, -1);
    chk("pin_rd_len", exp_tx.size(), 4);
    chk("pin_rd_data", {exp_tx[2].b, exp_tx[3].b}, 16'h5A6B);
    fr = '{8'h55, 8'h02, 8'hA0, 8'h01, 8'hFE, 8'h02};
    send_frame(fr);
    wait_done(500);

    // address wrap
    model(1, 16'hFFFF, 2, dq, -1);
    chk("pin_wrap_addr", exp_i2c[1].addr, 16'h0000);
    fr = '{8'h55, 8'h02, 8'hA0, 8'hFF, 8'hFF, 8'h02};
    send_frame(fr);
    wait_done(500);

    // NACK on the second byte
    dq = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
    nack_at = n_done + 1;
    model(0, 16'h0200, 4, dq, 1);
    chk("pin_nack_ops", exp_i2c.size(), 2);
    chk("pin_nack_resp", {exp_tx[0].b, exp_tx[1].b}, 16'hAA01);
    r0 = n_req;
    fr = '{8'h55, 8'h01, 8'hA0, 8'h02, 8'h00, 8'h04,
           8'hD1, 8'hD2, 8'hD3, 8'hD4};
    send_frame(fr);
    wait_done(500);
    nack_at = -1;
    chk("nack_reqs", n_req - r0, 2);

    // LEN=0
    model_bad();
    r0 = n_req;
    fr = '{8'h55, 8'h01, 8'hA0, 8'h00, 8'h20, 8'h00};
    send_frame(fr);
    wait_done(TMO * 4 + 200);
    chk("len0_noreq", n_req - r0, 0);
    chk_drain();

    // LEN>MAX_LEN with trailing bytes discarded
    model_bad();
    fr = '{8'h55, 8'h02, 8'hA0, 8'h00, 8'h20, 8'h11, 8'hAB, 8'h55};
    send_frame(fr);
    wait_done(TMO * 4 + 200);
    chk("len17_noreq", n_req - r0, 0);
    chk_drain();

    // bad command
    model_bad();
    fr = '{8'h55, 8'h07, 8'hA0, 8'h00, 8'h20, 8'h02};
    send_frame(fr);
    wait_done(TMO * 4 + 200);
    chk("badcmd_noreq", n_req - r0, 0);

    // partial frame times out silently
    fr = '{8'h55, 8'h02, 8'hA0, 8'h00, 8'h10};
    send_frame(fr);
    #1 chk("busy_partial", 32'(busy), 1);
    repeat (TMO + 10) @(posedge clk);
    #1 chk("busy_after_tmo", 32'(busy), 0);
    chk("tmo_noreq", n_req - r0, 0);

    // next frame accepted normally, single-byte write
    dq = '{8'h99};
    model(0, 16'h0100, 1, dq, -1);
    fr = '{8'h55, 8'h01, 8'hA0, 8'h01, 8'h00, 8'h01, 8'h99};
    send_frame(fr);
    wait_done(500);
    chk("tmo_next_mem", mem[16'h0100], 8'h99);

    // reset while waiting on I2C
    hold_done = 1;
    begin
      op_t o;
      o.rd = 1; o.addr = 16'h0300; o.data = 8'h00;
      exp_i2c.push_back(o);
    end
    fr = '{8'h55, 8'h02, 8'hA0, 8'h03, 8'h00, 8'h02};
    send_frame(fr);
    n = 0;
    while (exp_i2c.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst_req_seen", exp_i2c.size(), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    repeat (3) @(posedge clk);
    hold_done = 0;
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1 chk("rst_busy_low", 32'(busy), 0);
    chk("rst_no_resp", exp_tx.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
